// File: rtl/packet_framer_pkg.sv
// Shared word encodings, state type and header word builder for packet_framer.
package packet_framer_pkg;

  localparam logic [1:0]  PFX_HDR   = 2'b11;
  localparam logic [1:0]  PFX_PAY   = 2'b00;
  localparam logic [1:0]  PFX_FILL  = 2'b01;
  localparam logic [1:0]  PFX_TRL   = 2'b10;
  localparam logic [15:0] IDLE_WORD = 16'h0000;
  localparam logic [15:0] FILL_WORD = {PFX_FILL, 14'h0000};
  localparam int          HDR_WORDS = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TRAILER = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  function automatic logic [15:0] hdr_word(input logic [2:0]  idx,
                                           input logic [9:0]  board,
                                           input logic [29:0] cnt,
                                           input logic [9:0]  plen);
    logic [9:0] fld;
    case (idx)
      3'd0:    fld = board;
      3'd1:    fld = cnt[29:20];
      3'd2:    fld = cnt[19:10];
      3'd3:    fld = cnt[9:0];
      3'd4:    fld = plen;
      3'd5:    fld = board ^ cnt[29:20] ^ cnt[19:10] ^ cnt[9:0] ^ plen;
      default: fld = 10'h000;
    endcase
    return {PFX_HDR, 1'b0, idx, fld};
  endfunction

endpackage

// File: rtl/packet_framer.sv
// Transmit framer: six tagged header words, a fixed-length payload taken from a
// valid/ready source, an XOR trailer, then a minimum idle gap.
module packet_framer
  import packet_framer_pkg::*;
#(
  parameter int PAYLOAD_WORDS = 16,
  parameter int MIN_GAP       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  board_id,
  input  logic        trigger,
  input  logic [13:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        trig_drop
);

  localparam int         GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [9:0] PLEN     = 10'(PAYLOAD_WORDS);
  localparam logic [9:0] PAY_LAST = 10'(PAYLOAD_WORDS - 1);
  localparam logic [2:0] HDR_LAST = 3'(HDR_WORDS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);

  state_e        state_q, state_d;
  logic [2:0]    hdr_idx_q, hdr_idx_d;
  logic [9:0]    pay_cnt_q, pay_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [13:0]   xor_q, xor_d;
  logic [29:0]   evt_cnt_q, evt_cnt_d;
  logic [29:0]   hdr_cnt_q, hdr_cnt_d;
  logic [9:0]    board_q, board_d;
  logic          pending_q, pending_d;
  logic [15:0]   tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          trig_drop_q, trig_drop_d;
  logic          accept_s, gap_exit_s, start_s;

  assign accept_s   = in_valid & in_ready_q;
  assign gap_exit_s = (state_q == ST_GAP) && (gap_q == GAP_LAST);

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    pay_cnt_d   = pay_cnt_q;
    gap_d       = gap_q;
    xor_d       = xor_q;
    evt_cnt_d   = evt_cnt_q;
    hdr_cnt_d   = hdr_cnt_q;
    board_d     = board_q;
    pending_d   = pending_q;
    tx_data_d   = IDLE_WORD;
    tx_valid_d  = 1'b0;
    in_ready_d  = 1'b0;
    trig_drop_d = 1'b0;
    start_s     = 1'b0;

    case (state_q)
      ST_IDLE: start_s = trigger;
      ST_HEADER: begin
        tx_data_d  = hdr_word(hdr_idx_q, board_q, hdr_cnt_q, PLEN);
        tx_valid_d = 1'b1;
        if (hdr_idx_q == HDR_LAST) begin
          state_d    = ST_PAYLOAD;
          pay_cnt_d  = 10'd0;
          in_ready_d = 1'b1;
        end else begin
          hdr_idx_d = hdr_idx_q + 3'd1;
        end
      end
      // in_ready drops on the same edge that takes the final payload word
      ST_PAYLOAD: begin
        if (accept_s) begin
          tx_data_d  = {PFX_PAY, in_data};
          tx_valid_d = 1'b1;
          xor_d      = xor_q ^ in_data;
          if (pay_cnt_q == PAY_LAST) begin
            state_d = ST_TRAILER;
          end else begin
            pay_cnt_d  = pay_cnt_q + 10'd1;
            in_ready_d = 1'b1;
          end
        end else begin
          tx_data_d  = FILL_WORD;
          in_ready_d = 1'b1;
        end
      end
      ST_TRAILER: begin
        tx_data_d  = {PFX_TRL, xor_q};
        tx_valid_d = 1'b1;
        evt_cnt_d  = evt_cnt_q + 30'd1;
        gap_d      = {GW{1'b0}};
        state_d    = ST_GAP;
      end
      ST_GAP: begin
        if (gap_exit_s) begin
          if (pending_q || trigger) begin
            start_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A trigger on the gap-exit edge starts the next packet like an idle trigger
    if (start_s) begin
      state_d   = ST_HEADER;
      hdr_idx_d = 3'd0;
      xor_d     = 14'h0000;
      board_d   = board_id;
      hdr_cnt_d = evt_cnt_q;
      pending_d = pending_q & trigger;
    end else if (trigger && (state_q != ST_IDLE)) begin
      if (pending_q) begin
        trig_drop_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else begin
      pending_d = pending_q;
    end

    busy_d = (state_d != ST_IDLE) | pending_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_idx_q   <= 3'd0;
      pay_cnt_q   <= 10'd0;
      gap_q       <= {GW{1'b0}};
      xor_q       <= 14'h0000;
      evt_cnt_q   <= 30'd0;
      hdr_cnt_q   <= 30'd0;
      board_q     <= 10'h000;
      pending_q   <= 1'b0;
      tx_data_q   <= IDLE_WORD;
      tx_valid_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      trig_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      pay_cnt_q   <= pay_cnt_d;
      gap_q       <= gap_d;
      xor_q       <= xor_d;
      evt_cnt_q   <= evt_cnt_d;
      hdr_cnt_q   <= hdr_cnt_d;
      board_q     <= board_d;
      pending_q   <= pending_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      trig_drop_q <= trig_drop_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign trig_drop = trig_drop_q;

endmodule

// File: tb/tb_packet_framer.sv
// Scoreboard bench for packet_framer: a reference model queues expected words,
// a monitor compares every tx_valid word and checks the idle/filler stream.
`timescale 1ns/1ps
module tb_packet_framer;

  localparam int P = 4;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  board_id = 10'h000;
  logic        trigger = 1'b0;
  logic [13:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        busy;
  logic        trig_drop;

  always #5 clk = ~clk;

  packet_framer #(.PAYLOAD_WORDS(P), .MIN_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .board_id(board_id), .trigger(trigger),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .trig_drop(trig_drop)
  );

  typedef struct {
    logic [15:0] data;
    int          at_cyc;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  logic [13:0] src_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int src_acc = 0;
  int fill_cnt = 0;
  int drop_cnt = 0;
  int stall_at = -1;
  int stall_len = 0;
  int valid_pct = 100;
  logic [29:0] m_evt = 30'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [15:0] d, input int at, input int gap);
    exp_t e;
    e.data = d;
    e.at_cyc = at;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Builds one packet from the framing rules; w0_cyc<0 / gap<0 mean "don't care"
  task automatic model_packet(input int w0_cyc, input int gap);
    logic [9:0]  f [6];
    logic [13:0] x;
    logic [13:0] d;
    x = 14'h0000;
    f[0] = board_id;
    f[1] = m_evt[29:20];
    f[2] = m_evt[19:10];
    f[3] = m_evt[9:0];
    f[4] = 10'(P);
    f[5] = f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4];
    for (int i = 0; i < 6; i++)
      push_word({2'b11, 4'(i), f[i]}, (w0_cyc < 0) ? -1 : w0_cyc + i, (i == 0) ? gap : -1);
    for (int k = 0; k < P; k++) begin
      d = 14'($urandom);
      x = x ^ d;
      src_q.push_back(d);
      push_word({2'b00, d}, -1, -1);
    end
    push_word({2'b10, x}, -1, -1);
    m_evt = m_evt + 30'd1;
  endtask

  task automatic fire();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 400), 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: compares every valid word, checks non-valid words and gap lengths
  initial begin : monitor
    exp_t e;
    int idle_run;
    idle_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle_run = 0;
        continue;
      end
      if (trig_drop) drop_cnt++;
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h expected none (cycle %0d)", tx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("tx_word", tx_data, e.data);
          if (e.at_cyc >= 0) check("word_cycle", cyc, e.at_cyc);
          if (e.gap >= 0) check("gap_len", idle_run, e.gap);
        end
        idle_run = 0;
      end else if (tx_data == 16'h4000) begin
        fill_cnt++;
      end else begin
        check("invalid_word_idle", tx_data, 16'h0000);
        idle_run++;
      end
    end
  end

  // Payload source: valid/ready handshake with random or scripted stalls
  initial begin : source
    logic rdy;
    int stall_left;
    rdy = 1'b0;
    stall_left = 0;
    in_valid = 1'b0;
    in_data = 14'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_valid = 1'b0;
        rdy = 1'b0;
        continue;
      end
      if (in_valid && rdy) begin
        void'(src_q.pop_front());
        src_acc++;
      end
      rdy = in_ready;
      if (stall_at >= 0 && src_acc == stall_at) begin
        stall_left = stall_len;
        stall_at = -1;
      end
      if (stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        in_data = src_q[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] kat [6];
    int t, f0, d0;
    kat[0] = 16'hC2A5; kat[1] = 16'hC400; kat[2] = 16'hC800;
    kat[3] = 16'hCC00; kat[4] = 16'hD004; kat[5] = 16'hD6A1;

    #1 rst_n = 1'b0;
    #3;
    check("rst_tx_data", tx_data, 16'h0000);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_trig_drop", trig_drop, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Known-answer packet: board 2A5, data 1..4, event count 0
    board_id = 10'h2A5;
    t = cyc;
    for (int i = 0; i < 6; i++) push_word(kat[i], t + 2 + i, -1);
    for (int k = 1; k <= 4; k++) begin
      src_q.push_back(14'(k));
      push_word(16'(k), t + 7 + k, -1);
    end
    push_word(16'h8004, t + 12, -1);
    m_evt = 30'd1;
    fire();
    check("busy_after_trigger", busy, 1'b1);
    wait_idle("idle_kat");
    check("busy_idle", busy, 1'b0);

    // Second packet: event count 1 in w3
    model_packet(cyc + 2, -1);
    fire();
    wait_idle("idle_second");

    // Three-cycle stall mid-payload
    stall_at = src_acc + 2;
    stall_len = 3;
    f0 = fill_cnt;
    model_packet(cyc + 2, -1);
    fire();
    wait_idle("idle_stall");
    check("filler_count", fill_cnt - f0, 3);

    // Trigger during header -> pending; another one -> dropped
    board_id = 10'(($urandom));
    d0 = drop_cnt;
    model_packet(cyc + 2, -1);
    model_packet(-1, G);
    fire();
    @(negedge clk);
    @(negedge clk);
    fire();
    check("busy_pending", busy, 1'b1);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    check("trig_drop_pulse", trig_drop, 1'b1);
    @(negedge clk);
    check("trig_drop_clear", trig_drop, 1'b0);
    wait_idle("idle_pending");
    check("drop_count", drop_cnt - d0, 1);

    // Trigger on the gap-exit edge behaves like an idle trigger
    d0 = drop_cnt;
    t = cyc;
    model_packet(t + 2, -1);
    fire();
    wait_cyc(t + 7 + P + G);
    model_packet(cyc + 2, G);
    fire();
    wait_idle("idle_gap_exit");
    check("gap_exit_no_drop", drop_cnt - d0, 0);

    // Event counter wrap
    force dut.evt_cnt_q = 30'h3FFF_FFFF;
    repeat (3) @(negedge clk);
    release dut.evt_cnt_q;
    m_evt = 30'h3FFF_FFFF;
    model_packet(cyc + 2, -1);
    fire();
    wait_idle("idle_wrap_max");
    model_packet(cyc + 2, -1);
    fire();
    wait_idle("idle_wrap_zero");

    // Randomized packets with random source stalls
    valid_pct = 60;
    for (int n = 0; n < 6; n++) begin
      board_id = 10'($urandom);
      model_packet(cyc + 2, -1);
      fire();
      wait_idle("idle_random");
    end
    valid_pct = 100;

    // Reset during payload word 2
    board_id = 10'($urandom);
    t = cyc;
    model_packet(t + 2, -1);
    fire();
    wait_cyc(t + 9);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_data", tx_data, 16'h0000);
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    src_q.delete();
    m_evt = 30'd0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    model_packet(cyc + 2, -1);
    fire();
    wait_idle("idle_after_reset");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
